// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: accepts WORD_W-bit words over valid/ready, shifts each one
// MSB-first through an embedded Moore "1001" detector, and keeps a saturating
// match count. Detector state persists across words so patterns that span a
// word boundary are found.
// Build option: define SEQ_DETECT_CTRL_NONOVERLAP_EN for non-overlapping
// detection (S4 restarts from S0/S1 instead of reusing the trailing 1).
module seq_detect_ctrl #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   input  logic              clear_count,
   output logic              bit_out,
   output logic              bit_valid,
   output logic [2:0]        det_state,
   output logic              match_pulse,
   output logic [CNT_W-1:0]  match_count,
   output logic              word_done,
   output logic              busy
);

   localparam int unsigned BCW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ctrl_e;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } det_e;

   ctrl_e             ctrl_q, ctrl_d;
   det_e              det_q, det_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic              match_q, match_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // State registers; reset discards any word in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q  <= IDLE;
         det_q   <= S0;
         shreg_q <= '0;
         bcnt_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         det_q   <= det_d;
         shreg_q <= shreg_d;
         bcnt_q  <= bcnt_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   // Control FSM: word capture, bit sequencing and handshake outputs.
   always_comb begin
      ctrl_d    = ctrl_q;
      shreg_d   = shreg_q;
      bcnt_d    = bcnt_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      bit_valid = 1'b0;
      word_done = 1'b0;
      case (ctrl_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shreg_d = in_data;
               bcnt_d  = '0;
               ctrl_d  = SHIFT;
            end
         end
         SHIFT: begin
            busy      = 1'b1;
            bit_valid = 1'b1;
            shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
            bcnt_d    = bcnt_q + BCW'(1);
            if (bcnt_q == LAST_BIT) begin
               ctrl_d = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            word_done = 1'b1;
            ctrl_d    = IDLE;
         end
         default: ctrl_d = IDLE;
      endcase
      bit_out = bit_valid & shreg_q[WORD_W-1];
   end

   // Moore 1001 detector; advances only on edges that consume a bit.
   always_comb begin
      det_d = det_q;
      if (bit_valid) begin
         case (det_q)
            S0: det_d = bit_out ? S1 : S0;
            S1: det_d = bit_out ? S1 : S2;
            S2: det_d = bit_out ? S1 : S3;
            S3: det_d = bit_out ? S4 : S0;
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
            S4: det_d = bit_out ? S1 : S0;
`else
            S4: det_d = bit_out ? S1 : S2;
`endif
            default: det_d = S0;
         endcase
      end
   end

   // Match pulse and saturating counter; clear wins over a same-edge increment.
   always_comb begin
      match_d = bit_valid && (det_d == S4);
      cnt_d   = cnt_q;
      if (clear_count) begin
         cnt_d = '0;
      end else if (match_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign det_state   = det_q;
   assign match_pulse = match_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: randomized and directed words checked each
// cycle against a bit-history reference model of the 1001 detector.
module tb_seq_detect_ctrl;

   localparam int unsigned W     = 8;
   localparam int unsigned CW    = 4;
   localparam int unsigned VW    = 9 + CW;
   localparam int          CMAX  = (1 << CW) - 1;
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
   localparam bit NONOVL = 1'b1;
`else
   localparam bit NONOVL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          clear_count;
   logic          bit_out;
   logic          bit_valid;
   logic [2:0]    det_state;
   logic          match_pulse;
   logic [CW-1:0] match_count;
   logic          word_done;
   logic          busy;

   seq_detect_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .clear_count(clear_count), .bit_out(bit_out),
      .bit_valid(bit_valid), .det_state(det_state), .match_pulse(match_pulse),
      .match_count(match_count), .word_done(word_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Observed output vector; bit_out only meaningful while bit_valid.
   logic [VW-1:0] obs;
   assign obs = {in_ready, busy, bit_valid, bit_out & bit_valid, word_done,
                 match_pulse, det_state, match_count};

   int checks = 0;
   int errors = 0;
   int pulses_seen = 0;

   // Reference model: recent consumed bits, expected pulse/state/count.
   bit   hist[$];
   bit   m_pulse;
   int   m_det;
   int   m_cnt;
   bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic m_reset();
      hist.delete();
      m_pulse = 1'b0;
      m_det   = 0;
      m_cnt   = 0;
   endtask

   // One clock edge of the model: optionally consumes bit b; clr clears count.
   task automatic m_edge(input bit consume, input bit b, input bit clr);
      bit match = 1'b0;
      if (consume) begin
         hist.push_back(b);
         if (hist.size() > 4) void'(hist.pop_front());
         match = (hist.size() == 4) && (hist[0] == 1'b1) && (hist[1] == 1'b0)
                 && (hist[2] == 1'b0) && (hist[3] == 1'b1);
         if (match) begin
            m_det = 4;
            if (NONOVL) hist.delete();
         end else begin
            m_det = 0;
            for (int k = 1; k <= 3; k++) begin
               bit ok = (hist.size() >= k);
               for (int j = 0; j < k; j++)
                  if (ok && hist[hist.size() - k + j] != pat[j]) ok = 1'b0;
               if (ok) m_det = k;
            end
         end
      end
      m_pulse = match;
      if (clr) m_cnt = 0;
      else if (match && m_cnt < CMAX) m_cnt++;
   endtask

   function automatic logic [VW-1:0] exp_vec(input bit rdy, input bit bsy,
                                             input bit bv, input bit bo,
                                             input bit wd);
      return {rdy, bsy, bv, bo, wd, m_pulse, 3'(m_det), CW'(m_cnt)};
   endfunction

   // Sends one word and checks every cycle from accept to the next IDLE.
   task automatic drive_word(input logic [W-1:0] data, input int clr_at,
                             input bit junk, input bit rclr, input string tag);
      logic [VW-1:0] exp;
      bit clr;
      @(negedge clk);
      exp = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s idle obs=%h exp=%h", tag, obs, exp);
      end
      if (match_pulse === 1'b1) pulses_seen++;
      clr = rclr && ($urandom_range(0, 15) == 0);
      in_valid = 1'b1; in_data = data; clear_count = clr;
      @(posedge clk);
      m_edge(1'b0, 1'b0, clr);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         exp = exp_vec(1'b0, 1'b1, 1'b1, data[W-1-i], 1'b0);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s shift%0d obs=%h exp=%h", tag, i, obs, exp);
         end
         if (match_pulse === 1'b1) pulses_seen++;
         clr = (clr_at == i) || (rclr && ($urandom_range(0, 15) == 0));
         in_valid = junk; in_data = W'($urandom); clear_count = clr;
         @(posedge clk);
         m_edge(1'b1, data[W-1-i], clr);
      end
      @(negedge clk);
      exp = exp_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s done obs=%h exp=%h", tag, obs, exp);
      end
      if (match_pulse === 1'b1) pulses_seen++;
      clr = rclr && ($urandom_range(0, 15) == 0);
      in_valid = junk; in_data = W'($urandom); clear_count = clr;
      @(posedge clk);
      m_edge(1'b0, 1'b0, clr);
      in_valid = 1'b0; clear_count = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input string tag);
      logic [VW-1:0] exp;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         exp = exp_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s idle%0d obs=%h exp=%h", tag, i, obs, exp);
         end
         in_valid = 1'b0; clear_count = 1'b0;
         @(posedge clk);
         m_edge(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; clear_count = 1'b0; in_data = '0;
      m_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [VW-1:0] exp;
      do_reset();
      #1;
      exp = '0; exp[VW-1] = 1'b1;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset obs=%h exp=%h", obs, exp);
      end
   endtask

   task automatic test_pattern_92();
      do_reset();
      pulses_seen = 0;
      drive_word(8'h92, -1, 1'b0, 1'b0, "p92");
      @(negedge clk);
      if (match_pulse === 1'b1) pulses_seen++;
      checks++;
      if (match_count !== CW'(NONOVL ? 1 : 2)) begin
         errors++;
         $display("FAIL p92_count got=%0d want=%0d", match_count, NONOVL ? 1 : 2);
      end
      checks++;
      if (det_state !== 3'd2) begin
         errors++;
         $display("FAIL p92_det got=%0d want=2", det_state);
      end
      checks++;
      if (pulses_seen != (NONOVL ? 1 : 2)) begin
         errors++;
         $display("FAIL p92_pulses got=%0d want=%0d", pulses_seen, NONOVL ? 1 : 2);
      end
      @(posedge clk);
      m_edge(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_cross_boundary();
      do_reset();
      drive_word(8'h01, -1, 1'b0, 1'b0, "xb1");
      #1;
      checks++;
      if (match_count !== CW'(0)) begin
         errors++;
         $display("FAIL xb_word1 got=%0d want=0", match_count);
      end
      drive_word(8'h20, -1, 1'b0, 1'b0, "xb2");
      #1;
      checks++;
      if (match_count !== CW'(1)) begin
         errors++;
         $display("FAIL xb_word2 got=%0d want=1", match_count);
      end
   endtask

   task automatic test_saturate_clear();
      do_reset();
      for (int i = 0; i < 8; i++) drive_word(8'h99, -1, 1'b0, 1'b0, "sat");
      #1;
      checks++;
      if (match_count !== CW'(CMAX)) begin
         errors++;
         $display("FAIL sat_count got=%0d want=%0d", match_count, CMAX);
      end
      // Clear asserted on the edge that also completes a match (bit 3).
      drive_word(8'h99, 3, 1'b0, 1'b0, "clr");
      #1;
      checks++;
      if (match_count !== CW'(1)) begin
         errors++;
         $display("FAIL clr_count got=%0d want=1", match_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 6; i++)
         drive_word(W'($urandom), -1, 1'b1, 1'b0, "b2b");
   endtask

   task automatic test_reset_midword();
      logic [VW-1:0] exp;
      do_reset();
      drive_word(8'h09, -1, 1'b0, 1'b0, "pre");
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h99;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      m_reset();
      exp = '0; exp[VW-1] = 1'b1;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL midreset obs=%h exp=%h", obs, exp);
      end
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(12, "postrst");
      drive_word(8'h92, -1, 1'b0, 1'b0, "after");
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 40; i++) begin
         drive_word(W'($urandom), -1, 1'($urandom), 1'b1, "rnd");
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2), "rndidle");
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; clear_count = 1'b0;
      m_reset();
      test_reset();
      test_pattern_92();
      test_cross_boundary();
      test_saturate_clear();
      test_back_to_back();
      test_reset_midword();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
